// File: rtl/riscv_activity_seq.sv
// riscv_activity_seq: sequenced inverter-chain banks that inject controlled switching activity and count trigger toggles
module my_not (
  input  logic a,
  output logic y
);
  assign y = ~a;
endmodule

module riscv_activity_seq #(
  parameter int G_BANKS  = 8,
  parameter int G_CHAINS = 16,
  parameter int G_STAGE  = 7,
  parameter int G_DIV_W  = 8,
  parameter int G_CNT_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [1:0]         cfg_mode,
  input  logic [G_BANKS-1:0] cfg_mask,
  input  logic [G_DIV_W-1:0] cfg_div,
  input  logic [15:0]        cfg_burst_on,
  input  logic [15:0]        cfg_burst_off,
  input  logic [15:0]        cfg_seed,
  input  logic               start,
  input  logic               stop,
  input  logic               cnt_clr,
  output logic               busy,
  output logic [G_BANKS-1:0] bank_trig,
  output logic [G_CNT_W-1:0] toggle_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
  localparam logic [1:0] M_OFF = 2'd0, M_BURST = 2'd2, M_RAND = 2'd3;
  state_t state, state_n;
  logic [1:0] mode;
  logic [G_BANKS-1:0] mask, flip, trig_n;
  logic [G_DIV_W-1:0] div, div_cnt, div_cnt_n;
  logic [15:0] burst_on, burst_off, ph_cnt, ph_cnt_n, lfsr, lfsr_n;
  logic [G_CNT_W-1:0] cnt_n;
  logic [G_CNT_W+4:0] sum;
  logic [4:0] pop;
  logic tick, accept;
  for (genvar b = 0; b < G_BANKS; b++) begin : g_bank
    for (genvar c = 0; c < G_CHAINS; c++) begin : g_chain
      (* keep = "true", dont_touch = "true", allow_combinatorial_loops = "true" *)
      logic [G_STAGE:0] chain_unused;
      assign chain_unused[0] = bank_trig[b];
      for (genvar s = 0; s < G_STAGE; s++) begin : g_stage
        (* keep = "true", dont_touch = "true", allow_combinatorial_loops = "true" *)
        my_not u_not (.a(chain_unused[s]), .y(chain_unused[s+1]));
      end
    end
  end
  assign cfg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign accept = cfg_valid && cfg_ready;
  assign tick = busy && div_cnt == div;
  always_comb begin
    state_n = state;
    div_cnt_n = busy ? (tick ? '0 : div_cnt + G_DIV_W'(1)) : div_cnt;
    ph_cnt_n = ph_cnt;
    lfsr_n = accept ? (|cfg_seed ? cfg_seed : 16'hACE1) : lfsr;
    flip = '0;
    if (stop) state_n = IDLE;
    else if (state == IDLE) begin
      if (start && mode != M_OFF) begin
        state_n = RUN;
        div_cnt_n = '0;
        ph_cnt_n = '0;
      end
    end else if (tick && state == RUN) begin
      flip = mode == M_RAND ? lfsr[G_BANKS-1:0] & mask : mask;
      if (mode == M_RAND) lfsr_n = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      if (mode == M_BURST && burst_off != 16'd0) begin
        ph_cnt_n = ph_cnt + 16'd1;
        if (ph_cnt_n >= (burst_on == 16'd0 ? 16'd1 : burst_on)) begin
          state_n = GAP;
          ph_cnt_n = '0;
        end
      end
    end else if (tick) begin
      ph_cnt_n = ph_cnt + 16'd1;
      if (ph_cnt_n >= burst_off) begin
        state_n = RUN;
        ph_cnt_n = '0;
      end
    end
    trig_n = stop ? '0 : bank_trig ^ flip;
    pop = '0;
    for (int i = 0; i < G_BANKS; i++) pop = pop + 5'(flip[i]);
    sum = {5'd0, toggle_cnt} + (G_CNT_W+5)'(pop);
    cnt_n = cnt_clr ? '0 : |sum[G_CNT_W+4:G_CNT_W] ? '1 : sum[G_CNT_W-1:0];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mode <= M_OFF;
      mask <= '0;
      div <= '0;
      burst_on <= '0;
      burst_off <= '0;
      lfsr <= 16'hACE1;
      div_cnt <= '0;
      ph_cnt <= '0;
      bank_trig <= '0;
      toggle_cnt <= '0;
    end else begin
      state <= state_n;
      lfsr <= lfsr_n;
      div_cnt <= div_cnt_n;
      ph_cnt <= ph_cnt_n;
      bank_trig <= trig_n;
      toggle_cnt <= cnt_n;
      if (accept) begin
        mode <= cfg_mode;
        mask <= cfg_mask;
        div <= cfg_div;
        burst_on <= cfg_burst_on;
        burst_off <= cfg_burst_off;
      end
    end
  end
endmodule

// File: tb/tb_riscv_activity_seq.sv
// tb_riscv_activity_seq: random and directed stimulus scored against a tick/period-level model
module tb_riscv_activity_seq;
  logic clk = 0, rst_n = 0, cfg_valid = 0, start = 0, stop = 0, cnt_clr = 0;
  logic [1:0] cfg_mode = 0;
  logic [7:0] cfg_mask = 0, cfg_div = 0;
  logic [15:0] cfg_burst_on = 0, cfg_burst_off = 0, cfg_seed = 0;
  logic cfg_ready, busy, cfg_ready4, busy4;
  logic [7:0] bank_trig, bank_trig4;
  logic [31:0] toggle_cnt;
  logic [3:0] toggle_cnt4;
  typedef struct {
    logic [7:0] trig;
    logic [31:0] cnt;
    logic [3:0] cnt4;
    logic busy;
    logic ready;
  } exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  bit m_run;
  int m_t, m_k, m_div, m_on, m_off;
  logic [1:0] m_mode;
  logic [7:0] m_mask, m_trig;
  logic [15:0] m_lfsr;
  longint m_cnt, m_cnt4, snap;

  riscv_activity_seq dut (.clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_div(cfg_div), .cfg_burst_on(cfg_burst_on),
    .cfg_burst_off(cfg_burst_off), .cfg_seed(cfg_seed), .start(start), .stop(stop), .cnt_clr(cnt_clr),
    .busy(busy), .bank_trig(bank_trig), .toggle_cnt(toggle_cnt));
  riscv_activity_seq #(.G_CNT_W(4)) dut4 (.clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_mode(cfg_mode), .cfg_mask(cfg_mask), .cfg_div(cfg_div), .cfg_burst_on(cfg_burst_on),
    .cfg_burst_off(cfg_burst_off), .cfg_seed(cfg_seed), .start(start), .stop(stop), .cnt_clr(cnt_clr),
    .busy(busy4), .bank_trig(bank_trig4), .toggle_cnt(toggle_cnt4));

  always #5 clk = ~clk;

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endfunction

  // Expected outputs after the coming edge, from cycles-since-start and tick-index arithmetic
  task automatic model();
    logic [7:0] flip = 0;
    int on1;
    bit idle;
    if (!rst_n) begin
      m_run = 0; m_mode = 0; m_mask = 0; m_div = 0; m_on = 0; m_off = 0;
      m_lfsr = 16'hACE1; m_trig = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      idle = !m_run;
      on1 = m_on == 0 ? 1 : m_on;
      if (stop) begin
        m_run = 0;
        m_trig = 0;
      end else if (idle) begin
        if (start && m_mode != 0) begin
          m_run = 1; m_t = 0; m_k = 0;
        end
      end else begin
        m_t++;
        if (m_t % (m_div + 1) == 0) begin
          m_k++;
          case (m_mode)
            2'd1: flip = m_mask;
            2'd2: flip = (m_off == 0 || (m_k - 1) % (on1 + m_off) < on1) ? m_mask : 8'h00;
            2'd3: begin
              flip = m_lfsr[7:0] & m_mask;
              m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            end
            default: flip = 0;
          endcase
          m_trig ^= flip;
        end
      end
      if (idle && cfg_valid) begin
        m_mode = cfg_mode; m_mask = cfg_mask; m_div = int'(cfg_div);
        m_on = int'(cfg_burst_on); m_off = int'(cfg_burst_off);
        m_lfsr = cfg_seed == 0 ? 16'hACE1 : cfg_seed;
      end
      m_cnt += $countones(flip);
      m_cnt4 += $countones(flip);
      if (m_cnt > 64'hFFFFFFFF) m_cnt = 64'hFFFFFFFF;
      if (m_cnt4 > 15) m_cnt4 = 15;
      if (cnt_clr) begin
        m_cnt = 0;
        m_cnt4 = 0;
      end
    end
    q.push_back(exp_t'{m_trig, m_cnt[31:0], m_cnt4[3:0], m_run, !m_run});
  endtask

  task automatic cyc();
    model();
    @(negedge clk);
    #1;
    cfg_valid = 0; start = 0; stop = 0; cnt_clr = 0;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic cfg(input logic [1:0] md, input logic [7:0] mk, input logic [7:0] dv,
                     input logic [15:0] on, input logic [15:0] off, input logic [15:0] sd);
    cfg_mode = md; cfg_mask = mk; cfg_div = dv; cfg_burst_on = on; cfg_burst_off = off; cfg_seed = sd;
    cfg_valid = 1;
    cyc();
  endtask

  task automatic go();
    start = 1;
    cyc();
  endtask

  task automatic halt();
    stop = 1;
    cyc();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("trig", bank_trig, e.trig);
        chk("cnt", toggle_cnt, e.cnt);
        chk("busy", busy, e.busy);
        chk("ready", cfg_ready, e.ready);
        chk("trig4", bank_trig4, e.trig);
        chk("cnt4", toggle_cnt4, e.cnt4);
        chk("busy4", busy4, e.busy);
        chk("ready4", cfg_ready4, e.ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    #1;
    chk("rst_trig", bank_trig, 0);
    chk("rst_cnt", toggle_cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    run(2);
    rst_n = 1;
    // continuous, every cycle
    cfg(2'd1, 8'h0F, 8'd0, 16'd0, 16'd0, 16'd0);
    go();
    run(10);
    chk("t1_cnt", toggle_cnt, 40);
    chk("t1_busy", busy, 1);
    chk("t1_ready", cfg_ready, 0);
    // continuous, divided by 4
    halt();
    cfg(2'd1, 8'hFF, 8'd3, 16'd0, 16'd0, 16'd0);
    go();
    run(12);
    chk("t2_cnt", toggle_cnt, 64);
    // burst 3 on / 2 off
    halt();
    cnt_clr = 1;
    cyc();
    cfg(2'd2, 8'hFF, 8'd0, 16'd3, 16'd2, 16'd0);
    go();
    run(10);
    chk("t3_cnt", toggle_cnt, 48);
    // LFSR-random with odd banks masked off
    halt();
    cfg(2'd3, 8'h55, 8'd0, 16'd0, 16'd0, 16'd0);
    go();
    run(40);
    chk("t4_oddbits", bank_trig & 8'hAA, 0);
    // stop, config ignored while running, start+stop in idle
    halt();
    cfg(2'd1, 8'h0F, 8'd0, 16'd0, 16'd0, 16'd0);
    go();
    run(1);
    cfg(2'd2, 8'hFF, 8'd1, 16'd1, 16'd1, 16'd0);
    run(1);
    chk("t5_trig0F", bank_trig, 8'h0F);
    snap = m_cnt;
    halt();
    chk("t5_stop_trig", bank_trig, 0);
    chk("t5_stop_busy", busy, 0);
    chk("t5_stop_ready", cfg_ready, 1);
    chk("t5_stop_cnt", toggle_cnt, snap);
    go();
    run(1);
    chk("t5_cfg_kept", bank_trig, 8'h0F);
    halt();
    start = 1;
    stop = 1;
    cyc();
    chk("t5_start_stop", busy, 0);
    // saturation, clear on tick, async reset mid-run
    cnt_clr = 1;
    cyc();
    cfg(2'd1, 8'hFF, 8'd0, 16'd0, 16'd0, 16'd0);
    go();
    run(3);
    chk("t6_sat4", toggle_cnt4, 15);
    cnt_clr = 1;
    cyc();
    chk("t6_clr", toggle_cnt, 0);
    run(3);
    #1 rst_n = 0;
    #1;
    chk("t6_async_trig", bank_trig, 0);
    chk("t6_async_cnt", toggle_cnt, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_ready", cfg_ready, 1);
    cyc();
    rst_n = 1;
    // random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(7) == 0) begin
        cfg_valid = 1;
        cfg_mode = 2'($urandom_range(3));
        cfg_mask = 8'($urandom);
        cfg_div = 8'($urandom_range(3));
        cfg_burst_on = 16'($urandom_range(4));
        cfg_burst_off = 16'($urandom_range(3));
        cfg_seed = $urandom_range(3) == 0 ? 16'd0 : 16'($urandom);
      end
      start = $urandom_range(5) == 0;
      stop = $urandom_range(24) == 0;
      cnt_clr = $urandom_range(49) == 0;
      cyc();
    end
    run(2);
    chk("drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
